ram_banked: RTL and testbench

RAM_BANKED -- requirements
Module: ram_banked

---
 rtl/ram_banked.sv | 120 ++++++++++++
 tb/tb_ram_banked.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_banked.sv
// Banked single-port RAM with per-byte write enables and an optional zero-fill after reset.
// The bank index sits in the top address bits. Accesses to absent banks report ERR.
module ram_banked #(
    parameter int BLOCKS         = 4,
    parameter int WORDS          = 1024,
    parameter int DW             = 32,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB = DW / 8,
    localparam int WA = $clog2(WORDS),
    localparam int BA = 3,
    localparam int AW = WA + BA
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [NB-1:0] WE,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] Di,
    output logic [DW-1:0] Do,
    output logic          DV,
    output logic          ERR,
    output logic          RDY
);

    localparam logic [BA:0] NBLK = BLOCKS[BA:0];

    typedef enum logic {CLEAR, READY} state_t;

    state_t        state;
    logic [WA-1:0] clr_cnt;
    logic          clr_en;

    logic [BA-1:0] bank_p0;
    logic [WA-1:0] word_p0;
    logic          acc_p0;
    logic          we_any_p0;
    logic          in_rng_p0;

    logic [BA-1:0] rd_bank_p1;
    logic          rd_zero_p1;
    logic          vld_p1;
    logic          err_p1;
    logic [DW-1:0] q_bank [BLOCKS];

    // Stage p0: request decode
    assign bank_p0   = A[AW-1:WA];
    assign word_p0   = A[WA-1:0];
    assign acc_p0    = EN && RDY;
    assign we_any_p0 = |WE;
    assign in_rng_p0 = {1'b0, bank_p0} < NBLK;

    assign RDY    = (state == READY);
    assign clr_en = (CLEAR_ON_RESET != 0) && (state == CLEAR) && !RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            rd_bank_p1 <= '0;
            rd_zero_p1 <= 1'b1;
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (CLEAR_ON_RESET == 0) begin
                        state <= READY;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        // WORDS is a power of two, so all-ones marks the last word
                        if (&clr_cnt) state <= READY;
                    end
                end
                default: state <= READY;
            endcase
            vld_p1 <= acc_p0 && !we_any_p0;
            err_p1 <= acc_p0 && !in_rng_p0;
            if (acc_p0 && !we_any_p0) begin
                rd_bank_p1 <= bank_p0;
                rd_zero_p1 <= !in_rng_p0;
            end
        end
    end

    for (genvar b = 0; b < BLOCKS; b++) begin : g_bank
        logic [DW-1:0] mem [WORDS];
        logic [DW-1:0] q_p1;
        logic          en_p0;

        assign en_p0 = acc_p0 && in_rng_p0 && (bank_p0 == BA'(b));

        always_ff @(posedge CLK) begin
            if (clr_en) begin
                mem[clr_cnt] <= '0;
            end else if (en_p0) begin
                if (we_any_p0) begin
                    for (int i = 0; i < NB; i++) begin
                        if (WE[i]) mem[word_p0][i*8 +: 8] <= Di[i*8 +: 8];
                    end
                end else begin
                    q_p1 <= mem[word_p0];
                end
            end
        end

        assign q_bank[b] = q_p1;
    end

    // Stage p1: output select from the bank latched at acceptance
    always_comb begin
        Do = '0;
        for (int b = 0; b < BLOCKS; b++) begin
            if (!rd_zero_p1 && (rd_bank_p1 == BA'(b))) Do = q_bank[b];
        end
    end

    assign DV  = vld_p1;
    assign ERR = err_p1;

endmodule

// File: tb/tb_ram_banked.sv
// Bench for ram_banked: default instance against a behavioural memory model,
// plus small instances for a 3-bank and a no-clear configuration.
module tb_ram_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst_a, en_a, dv_a, err_a, rdy_a;
    logic [3:0]  we_a;
    logic [12:0] a_a;
    logic [31:0] di_a, do_a;

    // BLOCKS=3, WORDS=16
    logic        rst_b, en_b, dv_b, err_b, rdy_b;
    logic [3:0]  we_b;
    logic [6:0]  a_b;
    logic [31:0] di_b, do_b;

    // CLEAR_ON_RESET=0, BLOCKS=8, WORDS=16
    logic        rst_c, en_c, dv_c, err_c, rdy_c;
    logic [3:0]  we_c;
    logic [6:0]  a_c;
    logic [31:0] di_c, do_c;

    ram_banked u_dut (
        .CLK(clk), .RST(rst_a), .EN(en_a), .WE(we_a), .A(a_a), .Di(di_a),
        .Do(do_a), .DV(dv_a), .ERR(err_a), .RDY(rdy_a)
    );

    ram_banked #(.BLOCKS(3), .WORDS(16)) u_b3 (
        .CLK(clk), .RST(rst_b), .EN(en_b), .WE(we_b), .A(a_b), .Di(di_b),
        .Do(do_b), .DV(dv_b), .ERR(err_b), .RDY(rdy_b)
    );

    ram_banked #(.BLOCKS(8), .WORDS(16), .CLEAR_ON_RESET(0)) u_nc (
        .CLK(clk), .RST(rst_c), .EN(en_c), .WE(we_c), .A(a_c), .Di(di_c),
        .Do(do_c), .DV(dv_c), .ERR(err_c), .RDY(rdy_c)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] ref_mem [4][1024];
    logic [31:0] exp_do;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 1024; w++) ref_mem[b][w] = '0;
        exp_do = '0;
    endtask

    // counts edges until RDY rises on the default instance, bounded
    task automatic wait_rdy_a(output int n, output int dv_seen);
        n = 0;
        dv_seen = 0;
        while (!rdy_a && n < 2000) begin
            step();
            n++;
            if (dv_a || err_a) dv_seen++;
        end
    endtask

    // one cycle on the default instance, predicted from the address map
    task automatic op(input string tag, input logic en, input logic [3:0] we,
                      input logic [12:0] a, input logic [31:0] di);
        int  bank, word;
        logic exp_dv, exp_err;
        en_a = en; we_a = we; a_a = a; di_a = di;
        step();
        bank = int'(a) / 1024;
        word = int'(a) % 1024;
        exp_dv = 1'b0;
        exp_err = 1'b0;
        if (en) begin
            exp_err = (bank >= 4);
            if (we == 4'b0000) begin
                exp_dv = 1'b1;
                exp_do = (bank >= 4) ? 32'h0 : ref_mem[bank][word];
            end else if (bank < 4) begin
                for (int i = 0; i < 4; i++)
                    if (we[i]) ref_mem[bank][word][i*8 +: 8] = di[i*8 +: 8];
            end
        end
        chk({tag, ".do"}, 64'(do_a), 64'(exp_do));
        chk({tag, ".dv"}, 64'(dv_a), 64'(exp_dv));
        chk({tag, ".err"}, 64'(err_a), 64'(exp_err));
    endtask

    initial begin
        int n, seen;
        logic [12:0] ra;

        rst_a = 1'b1; en_a = 1'b0; we_a = '0; a_a = '0; di_a = '0;
        rst_b = 1'b1; en_b = 1'b0; we_b = '0; a_b = '0; di_b = '0;
        rst_c = 1'b1; en_c = 1'b0; we_c = '0; a_c = '0; di_c = '0;
        #1;
        chk("rst.do", 64'(do_a), 64'h0);
        chk("rst.dv", 64'(dv_a), 64'h0);
        chk("rst.err", 64'(err_a), 64'h0);
        chk("rst.rdy", 64'(rdy_a), 64'h0);
        step();
        step();

        // clear sequence with EN held high
        rst_a = 1'b0; en_a = 1'b1; a_a = 13'h0123;
        wait_rdy_a(n, seen);
        chk("clear.len", 64'(n), 64'd1024);
        chk("clear.quiet", 64'(seen), 64'd0);
        model_clear();

        op("rd_abc", 1'b1, 4'b0000, 13'h0ABC, 32'h0);
        chk("rd_abc.const", 64'(do_a), 64'h0);

        op("wr405a", 1'b1, 4'b1111, 13'h0405, 32'hDEADBEEF);
        op("wr405b", 1'b1, 4'b0010, 13'h0405, 32'h00001100);
        op("rd405", 1'b1, 4'b0000, 13'h0405, 32'h0);
        chk("rd405.const", 64'(do_a), 64'hDEAD11EF);

        op("wr001", 1'b1, 4'b1111, 13'h0001, 32'h11112222);
        op("wr401", 1'b1, 4'b1111, 13'h0401, 32'h33334444);
        op("idle", 1'b0, 4'b0000, 13'h0000, 32'h0);
        op("b2b0", 1'b1, 4'b0000, 13'h0001, 32'h0);
        chk("b2b0.const", 64'(do_a), 64'h11112222);
        op("b2b1", 1'b1, 4'b0000, 13'h0401, 32'h0);
        chk("b2b1.const", 64'(do_a), 64'h33334444);
        op("hold0", 1'b0, 4'b0000, 13'h0001, 32'h0);
        op("hold1", 1'b0, 4'b0000, 13'h1C00, 32'h0);
        op("hold2", 1'b1, 4'b1111, 13'h0401, 32'h55555555);
        chk("hold2.const", 64'(do_a), 64'h33334444);

        // asynchronous reset mid-cycle with an out-of-range read pending
        en_a = 1'b1; we_a = 4'b0000; a_a = 13'h1C00;
        #2 rst_a = 1'b1;
        #1;
        chk("arst.do", 64'(do_a), 64'h0);
        chk("arst.rdy", 64'(rdy_a), 64'h0);
        step();
        rst_a = 1'b0;
        step();
        chk("arst.dv", 64'(dv_a), 64'h0);
        chk("arst.err", 64'(err_a), 64'h0);

        // interrupt the clear part way through
        for (int i = 1; i < 500; i++) step();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        wait_rdy_a(n, seen);
        chk("reclear.len", 64'(n), 64'd1024);
        chk("reclear.quiet", 64'(seen), 64'd0);
        model_clear();
        op("zero405", 1'b1, 4'b0000, 13'h0405, 32'h0);
        chk("zero405.const", 64'(do_a), 64'h0);

        // randomized traffic, mostly in a small window to force address reuse
        for (int i = 0; i < 400; i++) begin
            ra[12:10] = 3'($urandom_range(0, 5));
            ra[9:0]   = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
            op("rand", $urandom_range(0, 3) != 0,
               ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom),
               ra, $urandom);
        end

        // three-bank instance
        rst_b = 1'b0;
        n = 0;
        while (!rdy_b && n < 100) begin step(); n++; end
        chk("b3.clear", 64'(n), 64'd16);
        en_b = 1'b1; we_b = 4'b1111; a_b = 7'h00; di_b = 32'h12345678;
        step();
        we_b = 4'b0000;
        step();
        chk("b3.rd0", 64'(do_b), 64'h12345678);
        a_b = 7'h30;
        step();
        chk("b3.oor.do", 64'(do_b), 64'h0);
        chk("b3.oor.dv", 64'(dv_b), 64'h1);
        chk("b3.oor.err", 64'(err_b), 64'h1);
        we_b = 4'b1111; di_b = 32'hFFFFFFFF;
        step();
        chk("b3.oorw.err", 64'(err_b), 64'h1);
        chk("b3.oorw.dv", 64'(dv_b), 64'h0);
        we_b = 4'b0000; a_b = 7'h00;
        step();
        chk("b3.rd0b", 64'(do_b), 64'h12345678);
        chk("b3.rd0b.err", 64'(err_b), 64'h0);
        en_b = 1'b0;

        // no-clear instance
        rst_c = 1'b0;
        chk("nc.rdy0", 64'(rdy_c), 64'h0);
        step();
        chk("nc.rdy1", 64'(rdy_c), 64'h1);
        en_c = 1'b1; we_c = 4'b1111; a_c = 7'h75; di_c = 32'hCAFEF00D;
        step();
        we_c = 4'b0000;
        step();
        chk("nc.rd.do", 64'(do_c), 64'hCAFEF00D);
        chk("nc.rd.err", 64'(err_c), 64'h0);
        en_c = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
